// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: RAW bubble insertion, branch flush and
// memory-wait freeze with a timeout trap, sitting beside the ID stage.
module pipeline_hazard_ctrl #(
    parameter bit          FORWARD_EN  = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_src1,
    input  logic [4:0]  id_src2,
    input  logic        id_two_src,
    input  logic [4:0]  exe_dest,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic [4:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic        br_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_freeze,
    output logic        if_id_freeze,
    output logic        if_id_flush,
    output logic        id_exe_flush,
    output logic        pipe_freeze,
    output logic        mem_error,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [15:0] stall_count_reg;

    logic hit_exe, hit_mem, data_stall, mem_pending, mem_stall;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign hit_exe = exe_wb_en && (exe_dest != 5'd0) &&
                     ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
    assign hit_mem = mem_wb_en && (mem_dest != 5'd0) &&
                     ((mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2)));

    assign data_stall  = id_valid && (FORWARD_EN ? (hit_exe && exe_mem_r_en)
                                                 : (hit_exe || hit_mem));
    assign mem_pending = mem_req && !mem_ready;
    assign mem_stall   = (state_reg == ERROR) || mem_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                if (mem_pending) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_pending) begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                    if (wait_cnt_reg == TIMEOUT_LAST)
                        state_next = ERROR;
                end else begin
                    // Completion or abort both release the pipeline.
                    state_next    = RUN;
                    wait_cnt_next = 8'd0;
                end
            end
            ERROR:   state_next = ERROR;
            default: begin
                state_next    = RUN;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

    always_comb begin
        pc_freeze    = 1'b0;
        if_id_freeze = 1'b0;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        pipe_freeze  = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                // A pending branch stays in the held registers and flushes on release.
                pipe_freeze  = 1'b1;
                pc_freeze    = 1'b1;
                if_id_freeze = 1'b1;
            end else if (br_taken) begin
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
            end else if (data_stall) begin
                pc_freeze    = 1'b1;
                if_id_freeze = 1'b1;
                id_exe_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count_reg <= 16'd0;
        else if (pc_freeze && (stall_count_reg != 16'hFFFF))
            stall_count_reg <= stall_count_reg + 16'd1;
    end

    assign stall_count = stall_count_reg;
    assign mem_error   = !rst && (state_reg == ERROR);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances (forwarding on/off)
// share stimulus; hazard table plus memory wait, timeout and saturation sequences.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic br_taken, mem_req, mem_ready;
    logic [4:0] id_src1, id_src2, exe_dest, mem_dest;

    logic pc_freeze_f, if_id_freeze_f, if_id_flush_f, id_exe_flush_f, pipe_freeze_f, mem_error_f;
    logic pc_freeze_n, if_id_freeze_n, if_id_flush_n, id_exe_flush_n, pipe_freeze_n, mem_error_n;
    logic [15:0] stall_count_f, stall_count_n;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FORWARD_EN(1'b1), .MEM_TIMEOUT(4)) dut_f (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(pc_freeze_f), .if_id_freeze(if_id_freeze_f), .if_id_flush(if_id_flush_f),
        .id_exe_flush(id_exe_flush_f), .pipe_freeze(pipe_freeze_f), .mem_error(mem_error_f),
        .stall_count(stall_count_f)
    );

    pipeline_hazard_ctrl #(.FORWARD_EN(1'b0), .MEM_TIMEOUT(4)) dut_n (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(pc_freeze_n), .if_id_freeze(if_id_freeze_n), .if_id_flush(if_id_flush_n),
        .id_exe_flush(id_exe_flush_n), .pipe_freeze(pipe_freeze_n), .mem_error(mem_error_n),
        .stall_count(stall_count_n)
    );

    // {pipe_freeze, pc_freeze, if_id_freeze, if_id_flush, id_exe_flush}
    logic [4:0] outs_f, outs_n;
    assign outs_f = {pipe_freeze_f, pc_freeze_f, if_id_freeze_f, if_id_flush_f, id_exe_flush_f};
    assign outs_n = {pipe_freeze_n, pc_freeze_n, if_id_freeze_n, if_id_flush_n, id_exe_flush_n};

    localparam logic [4:0] NONE  = 5'b00000;
    localparam logic [4:0] STALL = 5'b01101;
    localparam logic [4:0] FLUSH = 5'b00011;
    localparam logic [4:0] FRZ   = 5'b11100;

    typedef struct {
        logic       v;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       two;
        logic [4:0] ed;
        logic       ewb;
        logic       eld;
        logic [4:0] md;
        logic       mwb;
        logic       br;
        logic [4:0] exp_f;
        logic [4:0] exp_n;
    } vec_t;

    vec_t vecs[10];
    int checks = 0;
    int errors = 0;
    int cnt_f = 0;
    int cnt_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_hazard();
        id_valid = 1'b0; id_src1 = 5'd0; id_src2 = 5'd0; id_two_src = 1'b0;
        exe_dest = 5'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 5'd0; mem_wb_en = 1'b0; br_taken = 1'b0;
    endtask

    initial begin
        //          v     s1     s2     two   ed     ewb   eld   md     mwb   br    exp_f  exp_n
        vecs[0] = '{1'b1, 5'd5,  5'd0,  1'b0, 5'd5,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, STALL, STALL}; // load-use
        vecs[1] = '{1'b1, 5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, NONE,  NONE};  // r0
        vecs[2] = '{1'b1, 5'd1,  5'd7,  1'b0, 5'd7,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, NONE,  NONE};  // src2 unused
        vecs[3] = '{1'b1, 5'd1,  5'd7,  1'b1, 5'd7,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, STALL, STALL}; // src2 used
        vecs[4] = '{1'b1, 5'd3,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd3,  1'b1, 1'b0, NONE,  STALL}; // MEM hit
        vecs[5] = '{1'b1, 5'd4,  5'd0,  1'b0, 5'd4,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, NONE,  STALL}; // ALU in EXE
        vecs[6] = '{1'b1, 5'd5,  5'd0,  1'b0, 5'd5,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, FLUSH, FLUSH}; // branch wins
        vecs[7] = '{1'b0, 5'd5,  5'd0,  1'b0, 5'd5,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, NONE,  NONE};  // ID empty
        vecs[8] = '{1'b1, 5'd9,  5'd0,  1'b0, 5'd9,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, NONE,  NONE};  // no wb
        vecs[9] = '{1'b1, 5'd6,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd6,  1'b0, 1'b0, NONE,  NONE};  // MEM no wb

        rst = 1'b1; mem_req = 1'b0; mem_ready = 1'b0;
        idle_hazard();
        repeat (2) @(negedge clk);
        #2;
        chk("reset_outs_f", {27'd0, outs_f}, 32'd0);
        chk("reset_outs_n", {27'd0, outs_n}, 32'd0);
        chk("reset_cnt_err", {15'd0, mem_error_f, stall_count_f}, 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            id_valid = vecs[i].v; id_src1 = vecs[i].s1; id_src2 = vecs[i].s2;
            id_two_src = vecs[i].two; exe_dest = vecs[i].ed; exe_wb_en = vecs[i].ewb;
            exe_mem_r_en = vecs[i].eld; mem_dest = vecs[i].md; mem_wb_en = vecs[i].mwb;
            br_taken = vecs[i].br;
            #2;
            $display("vec %0d: outs_f=%b outs_n=%b", i, outs_f, outs_n);
            chk($sformatf("vec%0d_f", i), {27'd0, outs_f}, {27'd0, vecs[i].exp_f});
            chk($sformatf("vec%0d_n", i), {27'd0, outs_n}, {27'd0, vecs[i].exp_n});
            if (vecs[i].exp_f[3]) cnt_f++;
            if (vecs[i].exp_n[3]) cnt_n++;
        end
        @(negedge clk) idle_hazard();
        #2;
        chk("table_cnt_f", {16'd0, stall_count_f}, cnt_f);
        chk("table_cnt_n", {16'd0, stall_count_n}, cnt_n);

        // 4-cycle memory access with a branch pending throughout.
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            mem_req = 1'b1; mem_ready = (k == 4); br_taken = 1'b1;
            #2;
            $display("memwait cycle %0d: outs_f=%b", k, outs_f);
            chk($sformatf("memwait%0d_f", k), {27'd0, outs_f}, {27'd0, (k < 4) ? FRZ : FLUSH});
            chk($sformatf("memwait%0d_n", k), {27'd0, outs_n}, {27'd0, (k < 4) ? FRZ : FLUSH});
            if (k < 4) begin cnt_f++; cnt_n++; end
        end
        @(negedge clk);
        mem_req = 1'b0; mem_ready = 1'b0; br_taken = 1'b0;
        #2;
        chk("after_wait_outs", {27'd0, outs_f}, 32'd0);
        chk("after_wait_cnt_f", {16'd0, stall_count_f}, cnt_f);
        chk("after_wait_cnt_n", {16'd0, stall_count_n}, cnt_n);

        // Abort then zero-wait access.
        @(negedge clk) begin mem_req = 1'b1; mem_ready = 1'b0; end
        #2 chk("abort_start", {31'd0, pipe_freeze_f}, 32'd1);
        cnt_f++; cnt_n++;
        @(negedge clk) mem_req = 1'b0;
        #2 chk("abort_release", {31'd0, pipe_freeze_f}, 32'd0);
        @(negedge clk) begin mem_req = 1'b1; mem_ready = 1'b1; end
        #2 chk("zero_wait", {27'd0, outs_f}, 32'd0);
        @(negedge clk) begin mem_req = 1'b0; mem_ready = 1'b0; end
        #2 chk("zero_wait_cnt", {16'd0, stall_count_f}, cnt_f);

        // Timeout: four non-ready cycles lead to ERROR.
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk) begin mem_req = 1'b1; mem_ready = 1'b0; end
            #2;
            $display("timeout cycle %0d: outs_f=%b mem_error=%b", k, outs_f, mem_error_f);
            chk($sformatf("to%0d_frz", k), {31'd0, pipe_freeze_f}, 32'd1);
            chk($sformatf("to%0d_err", k), {30'd0, mem_error_f, mem_error_n}, 32'd0);
        end
        @(negedge clk) mem_req = 1'b0;
        #2;
        chk("error_flag", {30'd0, mem_error_f, mem_error_n}, 32'd3);
        chk("error_freeze", {27'd0, outs_f}, {27'd0, FRZ});

        // Saturation: ERROR holds the freeze indefinitely.
        repeat (65540) @(negedge clk);
        #2;
        chk("sat_f", {16'd0, stall_count_f}, 32'h0000FFFF);
        chk("sat_n", {16'd0, stall_count_n}, 32'h0000FFFF);
        repeat (3) @(negedge clk);
        #2 chk("sat_hold", {16'd0, stall_count_f}, 32'h0000FFFF);

        @(negedge clk) rst = 1'b1;
        #2;
        chk("rst_pulse_outs", {22'd0, outs_f, outs_n}, 32'd0);
        chk("rst_pulse_state", {14'd0, mem_error_f, mem_error_n, stall_count_f}, 32'd0);
        @(negedge clk) rst = 1'b0;
        #2;
        chk("post_rst", {15'd0, pipe_freeze_f, stall_count_n}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
